// File: rtl/frame_grab_pkg.sv
// Shared definitions for the frame-grab controller: register map, CTRL/STATUS
// bit positions, capture FSM states and the FIFO pixel entry layout.
package frame_grab_pkg;

  localparam logic [7:0] REG_CTRL   = 8'd0;
  localparam logic [7:0] REG_ROI_X  = 8'd1;
  localparam logic [7:0] REG_ROI_Y  = 8'd2;
  localparam logic [7:0] REG_DATA   = 8'd3;
  localparam logic [7:0] REG_FRAMES = 8'd4;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_CLEAR  = 3;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_OVF       = 2;
  localparam int STAT_IRQ_EN    = 3;
  localparam int STAT_LEVEL_LSB = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [7:0] pad;
  } pixel_t;

  function automatic pixel_t make_pixel(input logic [7:0] r, input logic [7:0] g,
                                        input logic [7:0] b);
    pixel_t p;
    p.r   = r;
    p.g   = g;
    p.b   = b;
    p.pad = 8'd0;
    return p;
  endfunction

endpackage

// File: rtl/frame_grab_ctrl_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head. Push when full and pop
// when empty are ignored; flush empties the FIFO in one cycle.
module sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_level   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + (AW+1)'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - (AW+1)'(1);
    end
  end

  // Storage has no reset; the pointers alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/frame_grab_ctrl.sv
// Avalon-MM slave that captures a frame-aligned rectangular region of the VGA
// pixel stream into a FIFO which software drains through the DATA register.
module frame_grab_ctrl
  import frame_grab_pkg::*;
#(
  parameter int FIFO_DEPTH = 64,
  parameter int COORD_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic [7:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic        vga_blank_n,
  input  logic        pix_en,
  output logic        irq
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic               r_hs, r_hs_prev, r_vs, r_vs_prev;
  logic [COORD_W-1:0] r_x, r_y;
  logic               r_line_seen;
  logic [COORD_W-1:0] r_roi_x0, r_roi_w, r_roi_y0, r_roi_h;
  state_t             r_state, w_state_nxt;
  logic               r_done, r_ovf, r_irq_en;
  logic [31:0]        r_frames;
  logic [31:0]        r_readdata;

  logic               w_sel_wr, w_sel_rd, w_wr_ctrl;
  logic               w_start, w_abort, w_go, w_zero_roi;
  logic               w_hs_fall, w_vs_fall, w_pix_valid;
  logic [COORD_W:0]   w_xe, w_ye, w_x_end, w_y_end;
  logic               w_in_win, w_last, w_hit;
  logic               w_push, w_flush, w_set_done, w_set_ovf, w_clr_flags;
  logic               w_pop;
  pixel_t             w_pix;
  logic [31:0]        w_fifo_head;
  logic               w_fifo_full, w_fifo_empty;
  logic [LVL_W-1:0]   w_level;
  logic [31:0]        w_status, w_rdata;

  assign w_sel_wr   = chipselect & write;
  assign w_sel_rd   = chipselect & read;
  assign w_wr_ctrl  = w_sel_wr && (address == REG_CTRL);
  assign w_start    = w_wr_ctrl & writedata[CTRL_START];
  assign w_abort    = w_wr_ctrl & writedata[CTRL_ABORT];
  assign w_go       = w_start & ~w_abort;
  assign w_zero_roi = (r_roi_w == '0) || (r_roi_h == '0);

  assign w_hs_fall   = r_hs_prev & ~r_hs;
  assign w_vs_fall   = r_vs_prev & ~r_vs;
  assign w_pix_valid = pix_en & vga_blank_n;

  // One extra bit so x0+width cannot wrap past the counter range.
  assign w_xe     = {1'b0, r_x};
  assign w_ye     = {1'b0, r_y};
  assign w_x_end  = {1'b0, r_roi_x0} + {1'b0, r_roi_w};
  assign w_y_end  = {1'b0, r_roi_y0} + {1'b0, r_roi_h};
  assign w_in_win = (w_xe >= {1'b0, r_roi_x0}) && (w_xe < w_x_end) &&
                    (w_ye >= {1'b0, r_roi_y0}) && (w_ye < w_y_end);
  assign w_last   = (w_xe == w_x_end - (COORD_W+1)'(1)) &&
                    (w_ye == w_y_end - (COORD_W+1)'(1));
  assign w_hit    = w_pix_valid & w_in_win;

  assign w_pix       = make_pixel(vga_r, vga_g, vga_b);
  assign w_clr_flags = w_flush | (w_wr_ctrl & writedata[CTRL_CLEAR]);
  assign w_pop       = w_sel_rd && (address == REG_DATA);
  assign irq         = r_done & r_irq_en;
  assign readdata    = r_readdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hs      <= 1'b1;
      r_hs_prev <= 1'b1;
      r_vs      <= 1'b1;
      r_vs_prev <= 1'b1;
    end else begin
      r_hs      <= vga_hs;
      r_hs_prev <= r_hs;
      r_vs      <= vga_vs;
      r_vs_prev <= r_vs;
    end
  end

  // line_seen keeps blank lines (porches, sync) from advancing y.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x         <= '0;
      r_y         <= '0;
      r_line_seen <= 1'b0;
    end else if (!r_vs) begin
      r_x         <= '0;
      r_y         <= '0;
      r_line_seen <= 1'b0;
    end else if (w_hs_fall) begin
      r_x <= '0;
      if (r_line_seen) begin
        r_y         <= r_y + COORD_W'(1);
        r_line_seen <= 1'b0;
      end
    end else if (w_pix_valid) begin
      r_x         <= r_x + COORD_W'(1);
      r_line_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_roi_x0 <= '0;
      r_roi_w  <= '0;
      r_roi_y0 <= '0;
      r_roi_h  <= '0;
      r_irq_en <= 1'b0;
      r_frames <= '0;
    end else begin
      if (w_sel_wr && address == REG_ROI_X && r_state == IDLE) begin
        r_roi_x0 <= writedata[COORD_W-1:0];
        r_roi_w  <= writedata[16 +: COORD_W];
      end
      if (w_sel_wr && address == REG_ROI_Y && r_state == IDLE) begin
        r_roi_y0 <= writedata[COORD_W-1:0];
        r_roi_h  <= writedata[16 +: COORD_W];
      end
      if (w_wr_ctrl) r_irq_en <= writedata[CTRL_IRQ_EN];
      if (w_vs_fall) r_frames <= r_frames + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_go && !w_zero_roi) w_state_nxt = ARM;
      ARM:     if (w_abort) w_state_nxt = IDLE;
               else if (w_vs_fall) w_state_nxt = CAPTURE;
      CAPTURE: if (w_abort) w_state_nxt = IDLE;
               else if (w_hit) begin
                 if (w_fifo_full || w_last) w_state_nxt = IDLE;
               end else if (w_vs_fall) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // A full FIFO drops the pixel and ends the capture without done.
  always_comb begin
    w_push     = 1'b0;
    w_flush    = 1'b0;
    w_set_done = 1'b0;
    w_set_ovf  = 1'b0;
    case (r_state)
      IDLE: begin
        w_flush    = w_go & ~w_zero_roi;
        w_set_done = w_go & w_zero_roi;
      end
      CAPTURE: begin
        if (!w_abort) begin
          if (w_hit) begin
            w_push     = ~w_fifo_full;
            w_set_ovf  = w_fifo_full;
            w_set_done = ~w_fifo_full & w_last;
          end else begin
            w_set_done = w_vs_fall;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_clr_flags) begin
        r_done <= 1'b0;
        r_ovf  <= 1'b0;
      end
      if (w_set_done) r_done <= 1'b1;
      if (w_set_ovf)  r_ovf  <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH(32),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_data  (w_pix),
    .i_pop   (w_pop),
    .o_head  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (w_level)
  );

  always_comb begin
    w_status                              = '0;
    w_status[STAT_LEVEL_LSB +: LVL_W]     = w_level;
    w_status[STAT_BUSY]                   = (r_state != IDLE);
    w_status[STAT_DONE]                   = r_done;
    w_status[STAT_OVF]                    = r_ovf;
    w_status[STAT_IRQ_EN]                 = r_irq_en;
  end

  always_comb begin
    w_rdata = '0;
    case (address)
      REG_CTRL:   w_rdata = w_status;
      REG_ROI_X:  w_rdata = (32'(r_roi_w) << 16) | 32'(r_roi_x0);
      REG_ROI_Y:  w_rdata = (32'(r_roi_h) << 16) | 32'(r_roi_y0);
      REG_DATA:   w_rdata = w_fifo_empty ? 32'd0 : w_fifo_head;
      REG_FRAMES: w_rdata = r_frames;
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)         r_readdata <= '0;
    else if (w_sel_rd) r_readdata <= w_rdata;
  end

endmodule

// File: tb/tb_frame_grab_ctrl.sv
// Directed bench for frame_grab_ctrl: drives a tiny 8x4 test frame and checks
// register reads against hand-computed values.
module tb_frame_grab_ctrl;
  import frame_grab_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect, write, read;
  logic [7:0]  address;
  logic [31:0] writedata, readdata;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vga_blank_n, pix_en;
  logic        irq;

  int          n_vec = 0;
  int          n_miss = 0;
  int          n_vs = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got, exp_v, last_pop;
  localparam logic [7:0] PIX_B = 8'hC3;

  always #5 clk = ~clk;

  frame_grab_ctrl #(.FIFO_DEPTH(8), .COORD_W(16)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .address(address),
    .write(write), .writedata(writedata), .read(read), .readdata(readdata),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .pix_en(pix_en), .irq(irq)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pix(input int x, input int y);
    return {8'(x), 8'(y), PIX_B, 8'h00};
  endfunction

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk); chipselect = 1; write = 1; address = a; writedata = d;
    @(negedge clk); chipselect = 0; write = 0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk); chipselect = 1; read = 1; address = a;
    @(negedge clk); chipselect = 0; read = 0; d = readdata;
  endtask

  task automatic vs_pulse();
    @(negedge clk); vga_vs = 0;
    repeat (3) @(negedge clk);
    vga_vs = 1;
    repeat (2) @(negedge clk);
    n_vs++;
  endtask

  task automatic hs_pulse();
    @(negedge clk); vga_hs = 0;
    repeat (2) @(negedge clk);
    vga_hs = 1;
    repeat (2) @(negedge clk);
  endtask

  // Eight active pixels, pix_en every other clock; optional DATA read aligned with pixel pop_x.
  task automatic send_line(input int y, input int pop_x);
    for (int x = 0; x < 8; x++) begin
      @(negedge clk);
      vga_blank_n = 1; pix_en = 1; vga_r = 8'(x); vga_g = 8'(y); vga_b = PIX_B;
      if (x == pop_x) begin chipselect = 1; read = 1; address = REG_DATA; end
      @(negedge clk);
      pix_en = 0;
      if (x == pop_x) begin chipselect = 0; read = 0; last_pop = readdata; end
    end
    @(negedge clk); vga_blank_n = 0;
  endtask

  task automatic send_frame();
    vs_pulse();
    for (int y = 0; y < 4; y++) begin
      send_line(y, -1);
      hs_pulse();
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);
    n_vec++; if (readdata !== 32'd0) begin n_miss++; $display("FAIL reset_readdata got %h exp 0", readdata); end
    n_vec++; if (irq !== 1'b0) begin n_miss++; $display("FAIL reset_irq got %b exp 0", irq); end
    bus_read(REG_CTRL, got);
    n_vec++; if (got !== 32'd0) begin n_miss++; $display("FAIL reset_status got %h exp 0", got); end
    bus_read(REG_FRAMES, got);
    n_vec++; if (got !== 32'd0) begin n_miss++; $display("FAIL reset_frames got %h exp 0", got); end
    bus_read(REG_ROI_X, got);
    n_vec++; if (got !== 32'd0) begin n_miss++; $display("FAIL reset_roi_x got %h exp 0", got); end
    bus_read(REG_DATA, got);
    n_vec++; if (got !== 32'd0) begin n_miss++; $display("FAIL reset_data_empty got %h exp 0", got); end
    bus_write(8'h10, 32'hFFFF_FFFF);
    bus_read(8'h10, got);
    n_vec++; if (got !== 32'd0) begin n_miss++; $display("FAIL unmapped_read got %h exp 0", got); end
  endtask

  task automatic test_basic_roi();
    bus_write(REG_ROI_X, 32'h0003_0002);
    bus_write(REG_ROI_Y, 32'h0002_0001);
    bus_write(REG_CTRL, 32'h1);
    bus_read(REG_CTRL, got);
    n_vec++; if (got !== 32'h0000_0001) begin n_miss++; $display("FAIL basic_armed got %h exp 00000001", got); end
    bus_write(REG_ROI_X, 32'h0009_0009);
    bus_read(REG_ROI_X, got);
    n_vec++; if (got !== 32'h0003_0002) begin n_miss++; $display("FAIL roi_write_while_busy got %h exp 00030002", got); end
    vs_pulse();
    for (int y = 0; y < 4; y++) begin
      send_line(y, -1);
      hs_pulse();
      if (y == 1) begin
        bus_read(REG_CTRL, got);
        n_vec++; if (got !== 32'h0003_0001) begin n_miss++; $display("FAIL basic_mid_frame got %h exp 00030001", got); end
      end
    end
    bus_read(REG_CTRL, got);
    n_vec++; if (got !== 32'h0006_0002) begin n_miss++; $display("FAIL basic_done got %h exp 00060002", got); end
    n_vec++; if (irq !== 1'b0) begin n_miss++; $display("FAIL basic_irq_disabled got %b exp 0", irq); end
    for (int y = 1; y <= 2; y++)
      for (int x = 2; x <= 4; x++) exp_q.push_back(pix(x, y));
    for (int i = 0; i < 6; i++) begin
      bus_read(REG_DATA, got);
      exp_v = exp_q.pop_front();
      n_vec++; if (got !== exp_v) begin n_miss++; $display("FAIL basic_data[%0d] got %h exp %h", i, got, exp_v); end
    end
    bus_read(REG_DATA, got);
    n_vec++; if (got !== 32'd0) begin n_miss++; $display("FAIL basic_data_empty got %h exp 0", got); end
    bus_read(REG_CTRL, got);
    n_vec++; if (got !== 32'h0000_0002) begin n_miss++; $display("FAIL basic_drained got %h exp 00000002", got); end
    bus_write(REG_CTRL, 32'h4);
    n_vec++; if (irq !== 1'b1) begin n_miss++; $display("FAIL irq_enable got %b exp 1", irq); end
    bus_write(REG_CTRL, 32'hC);
    n_vec++; if (irq !== 1'b0) begin n_miss++; $display("FAIL irq_clear got %b exp 0", irq); end
    bus_read(REG_CTRL, got);
    n_vec++; if (got !== 32'h0000_0008) begin n_miss++; $display("FAIL cleared_status got %h exp 00000008", got); end
    bus_write(REG_CTRL, 32'h0);
  endtask

  task automatic test_zero_size();
    bus_write(REG_ROI_X, 32'h0000_0002);
    bus_write(REG_CTRL, 32'h1);
    n_vec++; if (irq !== 1'b0) begin n_miss++; $display("FAIL zero_irq got %b exp 0", irq); end
    bus_read(REG_CTRL, got);
    n_vec++; if (got !== 32'h0000_0002) begin n_miss++; $display("FAIL zero_done got %h exp 00000002", got); end
    vs_pulse();
    send_line(0, -1);
    bus_read(REG_CTRL, got);
    n_vec++; if (got !== 32'h0000_0002) begin n_miss++; $display("FAIL zero_never_busy got %h exp 00000002", got); end
    bus_write(REG_CTRL, 32'h8);
  endtask

  task automatic test_overflow();
    bus_write(REG_ROI_X, 32'h0008_0000);
    bus_write(REG_ROI_Y, 32'h0002_0000);
    bus_write(REG_CTRL, 32'h1);
    send_frame();
    bus_read(REG_CTRL, got);
    n_vec++; if (got !== 32'h0008_0004) begin n_miss++; $display("FAIL overflow_status got %h exp 00080004", got); end
    for (int x = 0; x < 8; x++) exp_q.push_back(pix(x, 0));
    for (int i = 0; i < 8; i++) begin
      bus_read(REG_DATA, got);
      exp_v = exp_q.pop_front();
      n_vec++; if (got !== exp_v) begin n_miss++; $display("FAIL overflow_data[%0d] got %h exp %h", i, got, exp_v); end
    end
    bus_write(REG_CTRL, 32'h8);
    bus_read(REG_CTRL, got);
    n_vec++; if (got !== 32'h0) begin n_miss++; $display("FAIL overflow_cleared got %h exp 0", got); end
  endtask

  task automatic test_offscreen();
    bus_write(REG_ROI_X, 32'h0003_0064);
    bus_write(REG_ROI_Y, 32'h0002_0000);
    bus_write(REG_CTRL, 32'h1);
    send_frame();
    bus_read(REG_CTRL, got);
    n_vec++; if (got !== 32'h0000_0001) begin n_miss++; $display("FAIL offscreen_still_busy got %h exp 00000001", got); end
    vs_pulse();
    bus_read(REG_CTRL, got);
    n_vec++; if (got !== 32'h0000_0002) begin n_miss++; $display("FAIL offscreen_done got %h exp 00000002", got); end
    bus_write(REG_CTRL, 32'h8);
  endtask

  task automatic test_abort();
    bus_write(REG_ROI_X, 32'h0003_0002);
    bus_write(REG_ROI_Y, 32'h0002_0001);
    bus_write(REG_CTRL, 32'h1);
    bus_write(REG_CTRL, 32'h2);
    bus_read(REG_CTRL, got);
    n_vec++; if (got !== 32'h0) begin n_miss++; $display("FAIL abort_in_arm got %h exp 0", got); end
    send_frame();
    bus_read(REG_CTRL, got);
    n_vec++; if (got !== 32'h0) begin n_miss++; $display("FAIL abort_no_push got %h exp 0", got); end
    bus_write(REG_CTRL, 32'h1);
    vs_pulse();
    send_line(0, -1); hs_pulse();
    send_line(1, -1); hs_pulse();
    bus_write(REG_CTRL, 32'h2);
    bus_read(REG_CTRL, got);
    n_vec++; if (got !== 32'h0003_0000) begin n_miss++; $display("FAIL abort_in_capture got %h exp 00030000", got); end
    bus_write(REG_CTRL, 32'h3);
    bus_read(REG_CTRL, got);
    n_vec++; if (got !== 32'h0003_0000) begin n_miss++; $display("FAIL start_abort_same got %h exp 00030000", got); end
  endtask

  task automatic test_push_pop();
    bus_write(REG_ROI_X, 32'h0003_0002);
    bus_write(REG_ROI_Y, 32'h0001_0000);
    bus_write(REG_CTRL, 32'h1);
    bus_read(REG_CTRL, got);
    n_vec++; if (got !== 32'h0000_0001) begin n_miss++; $display("FAIL start_flush got %h exp 00000001", got); end
    vs_pulse();
    send_line(0, 3);
    hs_pulse();
    n_vec++; if (last_pop !== pix(2, 0)) begin n_miss++; $display("FAIL pushpop_old_head got %h exp %h", last_pop, pix(2, 0)); end
    bus_read(REG_CTRL, got);
    n_vec++; if (got !== 32'h0002_0002) begin n_miss++; $display("FAIL pushpop_level got %h exp 00020002", got); end
    exp_q.push_back(pix(3, 0));
    exp_q.push_back(pix(4, 0));
    for (int i = 0; i < 2; i++) begin
      bus_read(REG_DATA, got);
      exp_v = exp_q.pop_front();
      n_vec++; if (got !== exp_v) begin n_miss++; $display("FAIL pushpop_data[%0d] got %h exp %h", i, got, exp_v); end
    end
    bus_write(REG_CTRL, 32'h8);
  endtask

  task automatic test_frames();
    bus_read(REG_FRAMES, got);
    n_vec++; if (got !== 32'(n_vs)) begin n_miss++; $display("FAIL frames_count got %0d exp %0d", got, n_vs); end
  endtask

  task automatic test_reset_mid_capture();
    bus_write(REG_ROI_X, 32'h0003_0002);
    bus_write(REG_ROI_Y, 32'h0002_0001);
    bus_write(REG_CTRL, 32'h5);
    vs_pulse();
    send_line(0, -1); hs_pulse();
    send_line(1, -1); hs_pulse();
    bus_read(REG_CTRL, got);
    n_vec++; if (got !== 32'h0003_0009) begin n_miss++; $display("FAIL pre_reset_status got %h exp 00030009", got); end
    @(negedge clk); reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    n_vs = 0;
    n_vec++; if (readdata !== 32'd0) begin n_miss++; $display("FAIL midrst_readdata got %h exp 0", readdata); end
    n_vec++; if (irq !== 1'b0) begin n_miss++; $display("FAIL midrst_irq got %b exp 0", irq); end
    bus_read(REG_CTRL, got);
    n_vec++; if (got !== 32'd0) begin n_miss++; $display("FAIL midrst_status got %h exp 0", got); end
    bus_read(REG_FRAMES, got);
    n_vec++; if (got !== 32'd0) begin n_miss++; $display("FAIL midrst_frames got %h exp 0", got); end
    bus_read(REG_ROI_Y, got);
    n_vec++; if (got !== 32'd0) begin n_miss++; $display("FAIL midrst_roi_y got %h exp 0", got); end
    bus_read(REG_DATA, got);
    n_vec++; if (got !== 32'd0) begin n_miss++; $display("FAIL midrst_data got %h exp 0", got); end
  endtask

  initial begin
    reset = 1; chipselect = 0; write = 0; read = 0; address = '0; writedata = '0;
    vga_r = '0; vga_g = '0; vga_b = '0; vga_hs = 1; vga_vs = 1; vga_blank_n = 0; pix_en = 0;
    last_pop = '0;
    test_reset();
    test_basic_roi();
    test_zero_size();
    test_overflow();
    test_offscreen();
    test_abort();
    test_push_pop();
    test_frames();
    test_reset_mid_capture();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
